enemy_wave_controller: RTL and testbench

- Sequences a fixed set of enemy slots through game waves: staggered spawn, kill tracking, wave-clear detection and per-wave speed-up.
- Sits between the top-level game logic and the N enemy instances.
- Drives each enemy's enable line and a shared motion-timer maximum.
- Consumes each enemy's hit output and reports kill count, wave number and wave-clear events to scoring and HUD logic.

---
 rtl/enemy_wave_controller.sv | 152 +++++++++++++++
 tb/tb_enemy_wave_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_controller.sv
// Enemy wave sequencer: staggered slot spawn, edge-detected kill tracking,
// wave-clear detection and per-wave motion speed-up.
module enemy_wave_controller #(
    parameter int N_ENEMY        = 4,
    parameter int SPAWN_DELAY    = 50000000,
    parameter int CLEAR_DELAY    = 100000000,
    parameter int TIMER_MAX_INIT = 4000000,
    parameter int TIMER_STEP     = 250000,
    parameter int TIMER_MIN      = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               game_over,
    input  logic [N_ENEMY-1:0] enemy_hit,
    output logic [N_ENEMY-1:0] enemy_en,
    output logic [21:0]        motion_timer_max,
    output logic [7:0]         kill_count,
    output logic [3:0]         wave,
    output logic               wave_clear,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SPAWN, ACTIVE, WAVE_CLEAR} state_t;

    state_t             state, state_nxt;
    logic [N_ENEMY-1:0] hit_d;
    logic [N_ENEMY-1:0] en_nxt, kills, en_after, spawn_mask;
    logic [21:0]        tmax_nxt;
    logic [7:0]         kc_nxt, kc_sat;
    logic [3:0]         wave_nxt;
    logic               wclr_nxt, busy_nxt;
    logic [2:0]         slot, slot_nxt, spawn_slot;
    logic [31:0]        dly, dly_nxt;
    logic [3:0]         kill_pop;
    logic [8:0]         kill_sum;
    logic [22:0]        tmax_dec;

    // Kill bookkeeping shared by SPAWN and ACTIVE; unspawned slots are masked off.
    always_comb begin
        kills    = enemy_hit & ~hit_d & enemy_en;
        en_after = enemy_en & ~kills;
        kill_pop = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            kill_pop = kill_pop + {3'b000, kills[i]};
        end
        kill_sum   = {1'b0, kill_count} + {5'b00000, kill_pop};
        kc_sat     = kill_sum[8] ? 8'hFF : kill_sum[7:0];
        spawn_slot = slot + 3'd1;
        spawn_mask = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (3'(i) == spawn_slot) spawn_mask[i] = 1'b1;
        end
        // Extra MSB catches a borrow so the floor applies instead of wrapping.
        tmax_dec = {1'b0, motion_timer_max} - 23'(TIMER_STEP);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_nxt = state;
        en_nxt    = enemy_en;
        tmax_nxt  = motion_timer_max;
        kc_nxt    = kill_count;
        wave_nxt  = wave;
        wclr_nxt  = 1'b0;
        slot_nxt  = slot;
        dly_nxt   = dly;

        if (state != IDLE && game_over) begin
            state_nxt = IDLE;
            en_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (N_ENEMY == 1) ? ACTIVE : SPAWN;
                        en_nxt    = N_ENEMY'(1);
                        kc_nxt    = '0;
                        wave_nxt  = '0;
                        tmax_nxt  = 22'(TIMER_MAX_INIT);
                        slot_nxt  = '0;
                        dly_nxt   = '0;
                    end
                end
                SPAWN: begin
                    en_nxt = en_after;
                    kc_nxt = kc_sat;
                    if (dly == 32'(SPAWN_DELAY - 1)) begin
                        dly_nxt  = '0;
                        slot_nxt = spawn_slot;
                        en_nxt   = en_after | spawn_mask;
                        if (spawn_slot == 3'(N_ENEMY - 1)) state_nxt = ACTIVE;
                    end else begin
                        dly_nxt = dly + 32'd1;
                    end
                end
                ACTIVE: begin
                    en_nxt = en_after;
                    kc_nxt = kc_sat;
                    if (en_after == '0) begin
                        state_nxt = WAVE_CLEAR;
                        wclr_nxt  = 1'b1;
                        dly_nxt   = '0;
                    end
                end
                WAVE_CLEAR: begin
                    if (dly == 32'(CLEAR_DELAY - 1)) begin
                        state_nxt = (N_ENEMY == 1) ? ACTIVE : SPAWN;
                        wave_nxt  = (wave == 4'd15) ? wave : wave + 4'd1;
                        tmax_nxt  = (tmax_dec[22] || tmax_dec < 23'(TIMER_MIN))
                                    ? 22'(TIMER_MIN) : tmax_dec[21:0];
                        slot_nxt  = '0;
                        dly_nxt   = '0;
                        en_nxt    = N_ENEMY'(1);
                    end else begin
                        dly_nxt = dly + 32'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            enemy_en         <= '0;
            motion_timer_max <= 22'(TIMER_MAX_INIT);
            kill_count       <= '0;
            wave             <= '0;
            wave_clear       <= 1'b0;
            busy             <= 1'b0;
            slot             <= '0;
            dly              <= '0;
            hit_d            <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state            <= state_nxt;
            enemy_en         <= en_nxt;
            motion_timer_max <= tmax_nxt;
            kill_count       <= kc_nxt;
            wave             <= wave_nxt;
            wave_clear       <= wclr_nxt;
            busy             <= busy_nxt;
            slot             <= slot_nxt;
            dly              <= dly_nxt;
            hit_d            <= enemy_hit;
        end
    end

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots with their cycle;
// a negedge monitor pops one whenever any DUT output changes.
module tb_enemy_wave_controller;

    localparam int SD    = 4;
    localparam int CD    = 8;
    localparam int TINIT = 4000000;
    localparam int TSTEP = 250000;
    localparam int TMIN  = 1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        game_over = 1'b0;
    logic [3:0]  enemy_hit = 4'b0000;
    logic [3:0]  enemy_en;
    logic [21:0] motion_timer_max;
    logic [7:0]  kill_count;
    logic [3:0]  wave;
    logic        wave_clear;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [3:0]  en;
        logic [21:0] tmax;
        logic [7:0]  kills;
        logic [3:0]  wave;
        logic        wclr;
        logic        busy;
    } snap_t;

    snap_t      exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         nclr = 0;
    logic [3:0] e_en = 4'b0000;
    int         e_tmax = TINIT;
    int         e_kills = 0;
    int         e_wave = 0;
    logic       e_wclr = 1'b0;
    logic       e_busy = 1'b0;

    enemy_wave_controller #(
        .N_ENEMY(4), .SPAWN_DELAY(SD), .CLEAR_DELAY(CD),
        .TIMER_MAX_INIT(TINIT), .TIMER_STEP(TSTEP), .TIMER_MIN(TMIN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .game_over(game_over),
        .enemy_hit(enemy_hit), .enemy_en(enemy_en),
        .motion_timer_max(motion_timer_max), .kill_count(kill_count),
        .wave(wave), .wave_clear(wave_clear), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached with %0d snapshots pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: any output change must match the head of the expectation queue.
    initial begin
        snap_t cur, prev, e;
        bit    first;
        first = 1'b1;
        forever begin
            @(negedge clk);
            cur = '{cyc, enemy_en, motion_timer_max, kill_count, wave, wave_clear, busy};
            if (first || {cur.en, cur.tmax, cur.kills, cur.wave, cur.wclr, cur.busy} !==
                         {prev.en, prev.tmax, prev.kills, prev.wave, prev.wclr, prev.busy}) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cyc=%0d en=%b tmax=%0d kills=%0d wave=%0d wclr=%b busy=%b, required no change",
                             cur.cyc, cur.en, cur.tmax, cur.kills, cur.wave, cur.wclr, cur.busy);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc >= 0 && e.cyc != cur.cyc) ||
                        {cur.en, cur.tmax, cur.kills, cur.wave, cur.wclr, cur.busy} !==
                        {e.en, e.tmax, e.kills, e.wave, e.wclr, e.busy}) begin
                        errors++;
                        $display("FAIL snapshot: got cyc=%0d en=%b tmax=%0d kills=%0d wave=%0d wclr=%b busy=%b; required cyc=%0d en=%b tmax=%0d kills=%0d wave=%0d wclr=%b busy=%b",
                                 cur.cyc, cur.en, cur.tmax, cur.kills, cur.wave, cur.wclr, cur.busy,
                                 e.cyc, e.en, e.tmax, e.kills, e.wave, e.wclr, e.busy);
                    end
                end
            end
            first = 1'b0;
            prev  = cur;
        end
    end

    task automatic push(input int c);
        snap_t s;
        s.cyc   = c;
        s.en    = e_en;
        s.tmax  = 22'(e_tmax);
        s.kills = 8'(e_kills);
        s.wave  = 4'(e_wave);
        s.wclr  = e_wclr;
        s.busy  = e_busy;
        exp_q.push_back(s);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_kills(input int n);
        e_kills = (e_kills + n > 255) ? 255 : e_kills + n;
    endtask

    // Pulse start and queue the first nslots staggered enables.
    task automatic start_game(input int nslots, output int m);
        m = cyc;
        start = 1'b1;
        e_en = 4'b0001; e_busy = 1'b1; e_kills = 0; e_wave = 0; e_tmax = TINIT; e_wclr = 1'b0;
        nclr = 0;
        push(m + 1);
        for (int k = 1; k < nslots; k++) begin
            e_en[k] = 1'b1;
            push(m + 1 + SD * k);
        end
        wait_until(m + 1);
        start = 1'b0;
    endtask

    // Kill all remaining slots (mask), optionally holding some hit bits high
    // through the next spawn, then follow the clear delay and the re-spawn.
    task automatic clear_wave(input logic [3:0] mask, input int n, input logic [3:0] hold);
        int c, t;
        c = cyc;
        enemy_hit = mask;
        e_en = 4'b0000; add_kills(n); e_wclr = 1'b1;
        push(c + 1);
        wait_until(c + 1);
        enemy_hit = hold;
        e_wclr = 1'b0;
        push(c + 2);
        nclr++;
        e_wave = (nclr > 15) ? 15 : nclr;
        t = TINIT - TSTEP * nclr;
        e_tmax = (t < TMIN) ? TMIN : t;
        e_en = 4'b0001;
        push(c + 1 + CD);
        for (int k = 1; k < 4; k++) begin
            e_en[k] = 1'b1;
            push(c + 1 + CD + SD * k);
        end
        wait_until(c + 2 + CD + SD * 3);
        enemy_hit = 4'b0000;
        wait_until(c + 3 + CD + SD * 3);
    endtask

    initial begin
        int m, c;
        push(-1);
        wait_until(3);
        reset = 1'b1;
        wait_until(5);

        // Asynchronous reset in the middle of SPAWN with two slots enabled.
        start_game(2, m);
        wait_until(m + 7);
        reset = 1'b0;
        e_en = 4'b0000; e_busy = 1'b0;
        push(m + 7);
        wait_until(m + 9);
        reset = 1'b1;
        wait_until(m + 11);

        // Full staggered spawn into ACTIVE.
        start_game(4, m);
        wait_until(m + 14);

        // Two simultaneous kills, then one held hit that must count once.
        c = cyc;
        enemy_hit = 4'b0101;
        e_en = 4'b1010; e_kills = 2;
        push(c + 1);
        wait_until(c + 1);
        enemy_hit = 4'b0010;
        e_en = 4'b1000; e_kills = 3;
        push(c + 2);
        wait_until(c + 21);
        enemy_hit = 4'b0000;
        wait_until(c + 22);

        // Last kill clears the wave; hit held across the re-spawn of slot 3.
        clear_wave(4'b1000, 1, 4'b1000);

        // Many waves: timer floor, wave saturation, kill-count saturation.
        for (int w = 0; w < 64; w++) begin
            clear_wave(4'b1111, 4, 4'b0000);
        end

        // game_over with two kills in the same cycle.
        c = cyc;
        game_over = 1'b1;
        enemy_hit = 4'b0011;
        e_en = 4'b0000; e_busy = 1'b0;
        push(c + 1);
        wait_until(c + 1);
        game_over = 1'b0;
        enemy_hit = 4'b0000;
        wait_until(c + 3);

        // Restart: unspawned kills ignored, kill+spawn together, all spawned
        // slots dead during SPAWN without clearing, start ignored while busy.
        m = cyc;
        start = 1'b1;
        e_en = 4'b0001; e_busy = 1'b1; e_kills = 0; e_wave = 0; e_tmax = TINIT;
        nclr = 0;
        push(m + 1);
        wait_until(m + 1);
        start = 1'b0;
        wait_until(m + 2);
        enemy_hit = 4'b0110;
        wait_until(m + 3);
        enemy_hit = 4'b0000;
        wait_until(m + 4);
        enemy_hit = 4'b0001;
        e_en = 4'b0010; e_kills = 1;
        push(m + 5);
        wait_until(m + 5);
        enemy_hit = 4'b0000;
        wait_until(m + 6);
        enemy_hit = 4'b0010;
        start = 1'b1;
        e_en = 4'b0000; e_kills = 2;
        push(m + 7);
        wait_until(m + 7);
        enemy_hit = 4'b0000;
        start = 1'b0;
        e_en = 4'b0100;
        push(m + 9);
        e_en = 4'b1100;
        push(m + 13);
        wait_until(m + 14);
        clear_wave(4'b1100, 2, 4'b0000);

        c = cyc;
        game_over = 1'b1;
        e_en = 4'b0000; e_busy = 1'b0;
        push(c + 1);
        wait_until(c + 1);
        game_over = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected snapshots never observed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
